// File: rtl/sa_sched_pkg.sv
// Shared systolic-array definitions: scheduler state
// encoding and drain-length helper.
package sa_sched_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Cycles for the last operand to ripple out of an n x n array.
    function automatic int drain_len(input int n);
        return 2 * n - 1;
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// Enable-gated 1-bit shift line producing the per-row
// skewed valid for the systolic array.
module sa_skew_line #(
    parameter int N = 4
) (
    input  logic         en_clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic         din,
    output logic [N-1:0] q
);

    always_ff @(posedge en_clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[N-2:0], din};
        end
    end

endmodule

// File: rtl/sa_sched.sv
// Tile scheduler for an N x N systolic array: clear,
// feed k_len operand columns, drain, then pulse done.
module sa_sched
    import sa_sched_pkg::*;
#(
    parameter int N    = 4,
    parameter int K_BW = 8
) (
    input  logic            en_clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [K_BW-1:0] k_len,
    input  logic            stall,
    output logic            busy,
    output logic            acc_clr,
    output logic            rd_en,
    output logic [K_BW-1:0] rd_addr,
    output logic [N-1:0]    row_vld,
    output logic            pe_en,
    output logic            done
);

    localparam int DL = drain_len(N);
    localparam int CW = $clog2(2 * N);

    logic [2:0]      state;
    logic [K_BW-1:0] k_reg;
    logic [K_BW-1:0] addr_q;
    logic [CW-1:0]   dcnt;
    logic            launch;

    assign launch  = (state == S_IDLE) && start && (k_len != '0);
    assign busy    = (state != S_IDLE);
    assign acc_clr = (state == S_CLR);
    assign rd_en   = (state == S_FEED) && !stall;
    assign pe_en   = ((state == S_FEED) || (state == S_DRAIN)) && !stall;
    assign done    = (state == S_DONE);
    assign rd_addr = addr_q;

    always_ff @(posedge en_clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            k_reg  <= '0;
            addr_q <= '0;
            dcnt   <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (launch) begin
                        state  <= S_CLR;
                        k_reg  <= k_len;
                        addr_q <= '0;
                        dcnt   <= '0;
                    end
                end
                S_CLR: begin
                    state <= S_FEED;
                end
                S_FEED: begin
                    // Address parks on k_len-1 so it never wraps.
                    if (!stall) begin
                        if (addr_q == k_reg - K_BW'(1)) begin
                            state <= S_DRAIN;
                        end else begin
                            addr_q <= addr_q + K_BW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (!stall) begin
                        if (dcnt == CW'(DL - 1)) begin
                            state <= S_DONE;
                        end else begin
                            dcnt <= dcnt + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    sa_skew_line #(
        .N(N)
    ) u_skew (
        .en_clk(en_clk),
        .rst_n (rst_n),
        .en    (pe_en),
        .clr   (launch),
        .din   (rd_en),
        .q     (row_vld)
    );

endmodule

// File: tb/tb_sa_sched.sv
// Directed scoreboard bench for sa_sched (N=4, K_BW=8).
module tb_sa_sched;

    localparam int N  = 4;
    localparam int KW = 8;

    logic          en_clk = 1'b0;
    logic          rst_n  = 1'b0;
    logic          start  = 1'b0;
    logic          stall  = 1'b0;
    logic [KW-1:0] k_len  = '0;
    logic          busy;
    logic          acc_clr;
    logic          rd_en;
    logic [KW-1:0] rd_addr;
    logic [N-1:0]  row_vld;
    logic          pe_en;
    logic          done;

    int n_chk  = 0;
    int n_fail = 0;
    int q_addr[$];
    int q_done[$];

    always #5 en_clk = ~en_clk;

    sa_sched #(
        .N   (N),
        .K_BW(KW)
    ) dut (
        .en_clk (en_clk),
        .rst_n  (rst_n),
        .start  (start),
        .k_len  (k_len),
        .stall  (stall),
        .busy   (busy),
        .acc_clr(acc_clr),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .row_vld(row_vld),
        .pe_en  (pe_en),
        .done   (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One tile: start at c=0, stall over [st_lo,st_hi], optional
    // second start at xs_at. Expected reads/done go to queues.
    task automatic run_tile(input int k, input int done_c,
                            input int ncyc, input int st_lo,
                            input int st_hi, input int xs_at,
                            input int xs_k);
        int            reads;
        int            got;
        logic [N-1:0]  mrow;
        logic          erd;
        logic          epe;
        logic          sst;
        reads = 0;
        mrow  = '0;
        for (int c = 0; c < ncyc; c++) begin
            sst   = (c >= st_lo) && (c <= st_hi);
            start = (c == 0) || (c == xs_at);
            k_len = (c == xs_at) ? KW'(xs_k) : KW'(k);
            stall = sst;
            if (c == 0 && k != 0) begin
                for (int a = 0; a < k; a++) q_addr.push_back(a);
                q_done.push_back(done_c);
            end
            erd = (k != 0) && (c >= 2) && (reads < k) && !sst;
            epe = (k != 0) && (c >= 2) && (c < done_c) && !sst;
            @(negedge en_clk);
            chk("busy", 32'(busy), 32'((k != 0) && c >= 1 && c <= done_c));
            chk("acc_clr", 32'(acc_clr), 32'((k != 0) && c == 1));
            chk("rd_en", 32'(rd_en), 32'(erd));
            chk("pe_en", 32'(pe_en), 32'(epe));
            chk("row_vld", 32'(row_vld), 32'(mrow));
            if (rd_en) begin
                chk("rd_q_nonempty", 32'(q_addr.size() != 0), 32'd1);
                if (q_addr.size() != 0) begin
                    got = q_addr.pop_front();
                    chk("rd_addr", 32'(rd_addr), 32'(got));
                end
            end
            if (done) begin
                chk("done_q_nonempty", 32'(q_done.size() != 0), 32'd1);
                if (q_done.size() != 0) begin
                    got = q_done.pop_front();
                    chk("done_cycle", 32'(c), 32'(got));
                end
            end
            if (erd) reads++;
            if (epe) mrow = {mrow[N-2:0], erd};
            @(posedge en_clk);
            #1;
        end
        start = 1'b0;
        stall = 1'b0;
        if (k == 0 || ncyc > done_c + 1) begin
            chk("rd_left", 32'(q_addr.size()), 32'd0);
            chk("done_left", 32'(q_done.size()), 32'd0);
        end
    endtask

    initial begin
        repeat (3) @(posedge en_clk);
        @(negedge en_clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_row_vld", 32'(row_vld), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(posedge en_clk);
        #1;

        // Plain tile, k=3: done at cycle 12.
        run_tile(3, 12, 15, -1, -2, -1, 0);
        // Stall in FEED for two cycles: done slips to 14.
        run_tile(3, 14, 17, 3, 4, -1, 0);
        // Zero-length request is dropped.
        run_tile(0, -1, 6, -1, -2, -1, 0);
        // Start with k_len=5 mid-tile must be ignored.
        run_tile(3, 12, 15, -1, -2, 4, 5);

        // Abort in DRAIN via reset.
        run_tile(3, 12, 9, -1, -2, -1, 0);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_acc_clr", 32'(acc_clr), 32'd0);
        chk("abort_rd_en", 32'(rd_en), 32'd0);
        chk("abort_pe_en", 32'(pe_en), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_rd_addr", 32'(rd_addr), 32'd0);
        chk("abort_row_vld", 32'(row_vld), 32'd0);
        chk("abort_rd_left", 32'(q_addr.size()), 32'd0);
        q_done.delete();
        repeat (2) begin
            @(negedge en_clk);
            chk("abort_hold_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge en_clk);
        #1;
        run_tile(2, 11, 14, -1, -2, -1, 0);

        // Maximum length: last address 254, done at 2+255+7.
        run_tile(255, 264, 267, -1, -2, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
